// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : instr_fetch                                                      |
// | Purpose : Instruction fetch sequencer. Clears an external program counter, |
// |           presents its value to a ROM with one cycle of read latency,      |
// |           captures the returned word into an instruction register and      |
// |           holds it until the consumer accepts it, then fetches the next.   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   1  clock, rising edge                                    |
// |   clear_n    in   1  asynchronous active-low reset                         |
// |   start      in   1  begin / restart fetching from address 0               |
// |   stop       in   1  abort fetching, return to IDLE                        |
// |   pc_address in   7  current program-counter value                         |
// |   pc_up      out  1  increment request to the program counter              |
// |   pc_clear   out  1  synchronous clear request to the program counter      |
// |   mem_addr   out  7  ROM address (follows pc_address)                     |
// |   mem_data   in  16  ROM data, valid one cycle after mem_addr              |
// |   ir         out 16  instruction register                                  |
// |   ir_addr    out  7  address the instruction in ir came from              |
// |   ir_valid   out  1  ir holds an unconsumed instruction                    |
// |   ir_ready   in   1  consumer accepts ir this cycle                        |
// |   busy       out  1  fetcher active (not IDLE / HALT)                      |
// +----------------------------------------------------------------------------+
// | Build option                                                               |
// |   FETCH_HALT_ON_WRAP_EN : stop in a HALT state once the instruction from   |
// |                           address 127 is accepted instead of wrapping to 0.|
// +----------------------------------------------------------------------------+

module instr_fetch (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        start,
  input  logic        stop,
  input  logic [6:0]  pc_address,
  output logic        pc_up,
  output logic        pc_clear,
  output logic [6:0]  mem_addr,
  input  logic [15:0] mem_data,
  output logic [15:0] ir,
  output logic [6:0]  ir_addr,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ADDR  = 3'd2,
    S_READ  = 3'd3,
`ifdef FETCH_HALT_ON_WRAP_EN
    S_HOLD  = 3'd4,
    S_HALT  = 3'd5
`else
    S_HOLD  = 3'd4
`endif
  } state_t;

  state_t state;
  state_t next_state;
  logic   load_ir;
  logic   clr_valid;

  // The ROM address is the PC itself; the PC is only moved by pc_clear/pc_up.
  assign mem_addr = pc_address;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    pc_clear   = 1'b0;
    pc_up      = 1'b0;
    load_ir    = 1'b0;
    clr_valid  = 1'b0;
    busy       = 1'b1;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) next_state = S_CLEAR;
      end
      S_CLEAR: begin
        pc_clear   = 1'b1;
        next_state = S_ADDR;
      end
      S_ADDR: begin
        // ROM samples mem_addr on this edge; data is present during READ.
        next_state = S_READ;
      end
      S_READ: begin
        // PC advances on the same edge that captures the instruction.
        pc_up      = 1'b1;
        load_ir    = 1'b1;
        next_state = S_HOLD;
      end
      S_HOLD: begin
        if (ir_valid && ir_ready) begin
          clr_valid = 1'b1;
`ifdef FETCH_HALT_ON_WRAP_EN
          next_state = (ir_addr == 7'd127) ? S_HALT : S_ADDR;
`else
          next_state = S_ADDR;
`endif
        end
      end
`ifdef FETCH_HALT_ON_WRAP_EN
      S_HALT: begin
        busy = 1'b0;
        if (start) next_state = S_CLEAR;
      end
`endif
      default: begin
        next_state = S_IDLE;
      end
    endcase

    // stop overrides everything outside IDLE; a read in flight is dropped so
    // ir/ir_addr keep the last captured instruction.
    if (stop && (state != S_IDLE)) begin
      next_state = S_IDLE;
      load_ir    = 1'b0;
      clr_valid  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      ir       <= 16'h0000;
      ir_addr  <= 7'd0;
      ir_valid <= 1'b0;
    end else if (load_ir) begin
      ir       <= mem_data;
      ir_addr  <= pc_address;
      ir_valid <= 1'b1;
    end else if (clr_valid) begin
      ir_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_instr_fetch                                                   |
// | Purpose : Directed self-checking bench for instr_fetch. Provides a 7-bit   |
// |           program counter and a 128x16 ROM with one cycle read latency.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+

module tb_instr_fetch;

  logic        clk;
  logic        clear_n;
  logic        start;
  logic        stop;
  logic [6:0]  pc_address;
  logic        pc_up;
  logic        pc_clear;
  logic [6:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] ir;
  logic [6:0]  ir_addr;
  logic        ir_valid;
  logic        ir_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int up_cnt   = 0;
  int clr_cnt  = 0;
  int overlap  = 0;

  logic [15:0] rom [0:127];

  instr_fetch dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .start      (start),
    .stop       (stop),
    .pc_address (pc_address),
    .pc_up      (pc_up),
    .pc_clear   (pc_clear),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .ir         (ir),
    .ir_addr    (ir_addr),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External program counter
  always @(posedge clk or negedge clear_n) begin
    if (!clear_n)      pc_address <= 7'd0;
    else if (pc_clear) pc_address <= 7'd0;
    else if (pc_up)    pc_address <= pc_address + 7'd1;
  end

  // Synchronous ROM
  always @(posedge clk) mem_data <= rom[mem_addr];

  // Pulse bookkeeping
  always @(posedge clk) begin
    if (pc_up)             up_cnt  <= up_cnt + 1;
    if (pc_clear)          clr_cnt <= clr_cnt + 1;
    if (pc_up && pc_clear) overlap <= overlap + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy actual=%b expected=0", busy); end
    checks++; if (ir !== 16'h0000) begin failures++; $display("FAIL rst_ir actual=%h expected=0000", ir); end
    checks++; if (ir_addr !== 7'd0) begin failures++; $display("FAIL rst_ir_addr actual=%0d expected=0", ir_addr); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL rst_ir_valid actual=%b expected=0", ir_valid); end
    checks++; if ({pc_up, pc_clear} !== 2'b00) begin failures++; $display("FAIL rst_pc_ctl actual=%b expected=00", {pc_up, pc_clear}); end
    clear_n = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_start actual=%b expected=0", busy); end
  endtask

  task automatic test_basic_fetch();
    int cu0;
    int uu0;
    cu0 = clr_cnt;
    uu0 = up_cnt;
    ir_ready = 1'b1;
    start = 1'b1;
    tick();                          // edge 0 -> CLEAR
    start = 1'b0;
    checks++; if ({pc_clear, pc_up, busy} !== 3'b101) begin failures++; $display("FAIL clear_state actual=%b expected=101", {pc_clear, pc_up, busy}); end
    tick();                          // edge 1 -> ADDR
    checks++; if ({mem_addr, pc_clear} !== {7'd0, 1'b0}) begin failures++; $display("FAIL addr_state actual=%h expected=00", {mem_addr, pc_clear}); end
    tick();                          // edge 2 -> READ
    checks++; if ({pc_up, ir_valid} !== 2'b10) begin failures++; $display("FAIL read_state actual=%b expected=10", {pc_up, ir_valid}); end
    tick();                          // edge 3 -> HOLD
    checks++; if ({ir, ir_addr, ir_valid} !== {16'hA001, 7'd0, 1'b1}) begin failures++; $display("FAIL first_instr actual=%h/%0d/%b expected=a001/0/1", ir, ir_addr, ir_valid); end
    tick();
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL accept_clears_valid actual=%b expected=0", ir_valid); end
    tick();
    tick();
    checks++; if ({ir, ir_addr, ir_valid} !== {16'hB002, 7'd1, 1'b1}) begin failures++; $display("FAIL second_instr actual=%h/%0d/%b expected=b002/1/1", ir, ir_addr, ir_valid); end
    ir_ready = 1'b0;
    checks++; if (clr_cnt - cu0 !== 1) begin failures++; $display("FAIL pc_clear_pulses actual=%0d expected=1", clr_cnt - cu0); end
    checks++; if (up_cnt - uu0 !== 2) begin failures++; $display("FAIL pc_up_pulses actual=%0d expected=2", up_cnt - uu0); end
  endtask

  task automatic test_backpressure();
    int uu0;
    uu0 = up_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({ir, ir_addr, ir_valid} !== {16'hB002, 7'd1, 1'b1}) begin failures++; $display("FAIL bp_hold_%0d actual=%h/%0d/%b expected=b002/1/1", i, ir, ir_addr, ir_valid); end
    end
    checks++; if (up_cnt - uu0 !== 0) begin failures++; $display("FAIL bp_no_pc_up actual=%0d expected=0", up_cnt - uu0); end
    ir_ready = 1'b1;
    tick();
    checks++; if ({ir_valid, mem_addr} !== {1'b0, 7'd2}) begin failures++; $display("FAIL bp_resume actual=%b/%0d expected=0/2", ir_valid, mem_addr); end
    tick();
    tick();
    checks++; if ({ir, ir_addr, ir_valid} !== {16'h1002, 7'd2, 1'b1}) begin failures++; $display("FAIL bp_next_instr actual=%h/%0d/%b expected=1002/2/1", ir, ir_addr, ir_valid); end
    ir_ready = 1'b0;
  endtask

  task automatic test_stop();
    ir_ready = 1'b1;
    tick();                          // ADDR
    ir_ready = 1'b0;
    tick();                          // READ
    checks++; if (pc_up !== 1'b1) begin failures++; $display("FAIL stop_in_read actual=%b expected=1", pc_up); end
    stop = 1'b1;
    tick();                          // IDLE
    stop = 1'b0;
    checks++; if ({busy, ir_valid} !== 2'b00) begin failures++; $display("FAIL stop_idle actual=%b expected=00", {busy, ir_valid}); end
    checks++; if ({ir, ir_addr} !== {16'h1002, 7'd2}) begin failures++; $display("FAIL stop_ir_kept actual=%h/%0d expected=1002/2", ir, ir_addr); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checks++; if ({ir, ir_addr, ir_valid} !== {16'hA001, 7'd0, 1'b1}) begin failures++; $display("FAIL stop_restart actual=%h/%0d/%b expected=a001/0/1", ir, ir_addr, ir_valid); end
    // start while busy is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({busy, ir_valid, pc_clear, ir_addr} !== {1'b1, 1'b1, 1'b0, 7'd0}) begin failures++; $display("FAIL start_ignored actual=%b%b%b/%0d expected=110/0", busy, ir_valid, pc_clear, ir_addr); end
  endtask

  task automatic test_wrap();
    logic [6:0] ea;
    ir_ready = 1'b1;
    for (int i = 1; i < 128; i++) begin
      repeat (3) tick();
      ea = 7'(i);
      checks++; if ({ir_addr, ir_valid} !== {ea, 1'b1}) begin failures++; $display("FAIL wrap_seq actual=%0d/%b expected=%0d/1", ir_addr, ir_valid, ea); end
      if (i == 126) begin
        checks++; if (ir !== 16'h107E) begin failures++; $display("FAIL wrap_ir126 actual=%h expected=107e", ir); end
      end
    end
    checks++; if (ir !== 16'h107F) begin failures++; $display("FAIL wrap_ir127 actual=%h expected=107f", ir); end
`ifdef FETCH_HALT_ON_WRAP_EN
    tick();
    checks++; if ({busy, ir_valid, ir_addr} !== {1'b0, 1'b0, 7'd127}) begin failures++; $display("FAIL halt_enter actual=%b%b/%0d expected=00/127", busy, ir_valid, ir_addr); end
    ir_ready = 1'b0;
    tick();
    checks++; if ({busy, pc_up, ir_valid} !== 3'b000) begin failures++; $display("FAIL halt_stay actual=%b expected=000", {busy, pc_up, ir_valid}); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({pc_clear, busy} !== 2'b11) begin failures++; $display("FAIL halt_restart actual=%b expected=11", {pc_clear, busy}); end
    repeat (3) tick();
    checks++; if ({ir, ir_addr, ir_valid} !== {16'hA001, 7'd0, 1'b1}) begin failures++; $display("FAIL halt_refetch actual=%h/%0d/%b expected=a001/0/1", ir, ir_addr, ir_valid); end
`else
    tick();
    checks++; if ({busy, mem_addr} !== {1'b1, 7'd0}) begin failures++; $display("FAIL wrap_pc actual=%b/%0d expected=1/0", busy, mem_addr); end
    tick();
    tick();
    checks++; if ({ir, ir_addr, ir_valid} !== {16'hA001, 7'd0, 1'b1}) begin failures++; $display("FAIL wrap_addr0 actual=%h/%0d/%b expected=a001/0/1", ir, ir_addr, ir_valid); end
    repeat (3) tick();
    checks++; if ({ir, ir_addr, ir_valid} !== {16'hB002, 7'd1, 1'b1}) begin failures++; $display("FAIL wrap_addr1 actual=%h/%0d/%b expected=b002/1/1", ir, ir_addr, ir_valid); end
    ir_ready = 1'b0;
`endif
  endtask

  task automatic test_async_reset();
    int cu0;
    checks++; if ({ir_valid, busy} !== 2'b11) begin failures++; $display("FAIL pre_reset_hold actual=%b expected=11", {ir_valid, busy}); end
    #3;
    clear_n = 1'b0;
    #1;
    checks++; if ({ir_valid, busy} !== 2'b00) begin failures++; $display("FAIL async_rst_ctl actual=%b expected=00", {ir_valid, busy}); end
    checks++; if ({ir, ir_addr} !== {16'h0000, 7'd0}) begin failures++; $display("FAIL async_rst_ir actual=%h/%0d expected=0000/0", ir, ir_addr); end
    checks++; if ({pc_up, pc_clear} !== 2'b00) begin failures++; $display("FAIL async_rst_pc actual=%b expected=00", {pc_up, pc_clear}); end
    tick();
    clear_n = 1'b1;
    cu0 = clr_cnt;
    repeat (4) tick();
    checks++; if ({busy, ir_valid} !== 2'b00 || clr_cnt != cu0) begin failures++; $display("FAIL post_reset_idle actual=%b/%0d expected=00/0", {busy, ir_valid}, clr_cnt - cu0); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 16'h1000 + 16'(i);
    rom[0] = 16'hA001;
    rom[1] = 16'hB002;
    clear_n  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    ir_ready = 1'b0;
    tick();
    tick();
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_stop();
    test_wrap();
    test_async_reset();
    checks++; if (overlap != 0) begin failures++; $display("FAIL pc_overlap actual=%0d expected=0", overlap); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
